// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master: FSM encoding,
// wait-state timeout and the address bit that picks the slave.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Last wait-counter value tolerated before a transfer is aborted.
    localparam logic [3:0] TIMEOUT = 4'd15;

    // PADDR bit that selects slave 2 (1) or slave 1 (0).
    localparam int SEL_BIT = 6;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the last-grant
// register also serves as the id of the transfer currently in flight.
module apb_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_elig0,
    input  logic i_elig1,
    input  logic i_latch,
    output logic o_gnt,
    output logic o_last
);

    logic r_last;

    // On a tie favour whoever was not granted last; otherwise the lone eligible wins.
    assign o_gnt  = (i_elig0 & i_elig1) ? ~r_last : i_elig1;
    assign o_last = r_last;

    // Remember the winner whenever a grant is taken; reset so requester 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_latch) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters. Round-robin grant in IDLE, then a
// standard SETUP/ACCESS transfer with a wait-state timeout. All outputs
// are registered.
module apb_master_arb
    import apb_arb_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic       PREADY,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2
);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_latch;
    logic       w_gnt;
    logic       w_id;
    logic       w_g_write;
    logic [7:0] w_g_addr;
    logic [7:0] w_g_wdata;
    logic [7:0] w_prdata;

    // A requester whose done is showing this cycle cannot be re-granted yet.
    assign w_elig0 = req0_valid & ~done0;
    assign w_elig1 = req1_valid & ~done1;
    assign w_latch = (r_state == ST_IDLE) & (w_elig0 | w_elig1);

    assign w_g_write = w_gnt ? req1_write : req0_write;
    assign w_g_addr  = w_gnt ? req1_addr  : req0_addr;
    assign w_g_wdata = w_gnt ? req1_wdata : req0_wdata;
    assign w_prdata  = PADDR[SEL_BIT] ? PRDATA2 : PRDATA1;

    apb_rr_arb2 u_arb (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_elig0 (w_elig0),
        .i_elig1 (w_elig1),
        .i_latch (w_latch),
        .o_gnt   (w_gnt),
        .o_last  (w_id)
    );

    // Transfer FSM: latch the winner, run SETUP then ACCESS until PREADY or timeout.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= 8'd0;
            err     <= 1'b0;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 8'd0;
            PWDATA  <= 8'd0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_latch) begin
                        r_state <= ST_SETUP;
                        PWRITE  <= w_g_write;
                        PADDR   <= w_g_addr;
                        PWDATA  <= w_g_wdata;
                        PSEL1   <= ~w_g_addr[SEL_BIT];
                        PSEL2   <= w_g_addr[SEL_BIT];
                        PENABLE <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    r_cnt   <= 4'd0;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY || (r_cnt == TIMEOUT)) begin
                        // Normal completion or timeout abort; both end with a done pulse.
                        r_state <= ST_IDLE;
                        PSEL1   <= 1'b0;
                        PSEL2   <= 1'b0;
                        PENABLE <= 1'b0;
                        done0   <= ~w_id;
                        done1   <= w_id;
                        err     <= ~PREADY;
                        rdata   <= (PREADY && !PWRITE) ? w_prdata : 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    PSEL1   <= 1'b0;
                    PSEL2   <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle to a transfer-level model.
module tb_apb_master_arb;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       req0_valid = 1'b0, req0_write = 1'b0;
    logic [7:0] req0_addr = 8'd0, req0_wdata = 8'd0;
    logic       req1_valid = 1'b0, req1_write = 1'b0;
    logic [7:0] req1_addr = 8'd0, req1_wdata = 8'd0;
    logic       PREADY = 1'b0;
    logic [7:0] PRDATA1 = 8'd0, PRDATA2 = 8'd0;
    logic       done0, done1, err, PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] rdata, PADDR, PWDATA;

    int n_chk = 0;
    int n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arb dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    // m_age counts cycles since the grant: 0 is the setup cycle, 1.. are access cycles.
    logic       m_busy, m_gid, m_last, m_write;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic       m_done0, m_done1, m_err;
    int         m_age;

    wire m_e0   = req0_valid && !m_done0;
    wire m_e1   = req1_valid && !m_done1;
    wire m_pick = (m_e0 && m_e1) ? !m_last : m_e1;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_busy <= 0; m_age <= 0; m_gid <= 0; m_last <= 1; m_write <= 0;
            m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_done0 <= 0; m_done1 <= 0; m_err <= 0;
        end else begin
            m_done0 <= 0;
            m_done1 <= 0;
            if (!m_busy) begin
                if (m_e0 || m_e1) begin
                    m_busy  <= 1;
                    m_age   <= 0;
                    m_gid   <= m_pick;
                    m_last  <= m_pick;
                    m_write <= m_pick ? req1_write : req0_write;
                    m_addr  <= m_pick ? req1_addr : req0_addr;
                    m_wdata <= m_pick ? req1_wdata : req0_wdata;
                end
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (PREADY || m_age == 16) begin
                m_busy  <= 0;
                m_done0 <= (m_gid == 1'b0);
                m_done1 <= (m_gid == 1'b1);
                m_err   <= !PREADY;
                m_rdata <= (!PREADY || m_write) ? 8'h00 : (m_addr[6] ? PRDATA2 : PRDATA1);
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge PCLK) begin
        check("psel1",   PSEL1,   32'(m_busy && !m_addr[6]));
        check("psel2",   PSEL2,   32'(m_busy && m_addr[6]));
        check("penable", PENABLE, 32'(m_busy && m_age >= 1));
        check("pwrite",  PWRITE,  32'(m_write));
        check("paddr",   PADDR,   32'(m_addr));
        check("pwdata",  PWDATA,  32'(m_wdata));
        check("done0",   done0,   32'(m_done0));
        check("done1",   done1,   32'(m_done1));
        check("done_excl", 32'(done0 && done1), 32'd0);
        if (m_done0 || m_done1) begin
            check("rdata", rdata, 32'(m_rdata));
            check("err",   err,   32'(m_err));
        end
    end

    task automatic cyc();
        @(negedge PCLK);
    endtask

    logic stingy = 1'b0;

    initial begin
        int seq[$];
        int prev;
        int acc;
        bit got;
        bit after_done;

        // ---- reset state ----
        cyc();
        check("rst_psel1", PSEL1, 0); check("rst_penable", PENABLE, 0);
        check("rst_done0", done0, 0); check("rst_paddr", PADDR, 0);
        PRESET = 0;

        // ---- read, slave 1, ready in first access cycle ----
        req0_valid = 1; req0_write = 0; req0_addr = 8'h05; PREADY = 1;
        PRDATA1 = 8'hA5; PRDATA2 = 8'h5A;
        cyc(); check("rd_setup_psel1", PSEL1, 1); check("rd_setup_penable", PENABLE, 0);
        check("rd_setup_psel2", PSEL2, 0);
        cyc(); check("rd_acc_psel1", PSEL1, 1); check("rd_acc_penable", PENABLE, 1);
        check("rd_acc_paddr", PADDR, 8'h05);
        cyc(); check("rd_done0", done0, 1); check("rd_rdata", rdata, 8'hA5);
        check("rd_err", err, 0); check("rd_psel1_off", PSEL1, 0);
        req0_valid = 0; PREADY = 0;
        cyc();

        // ---- write, slave 2, ready after two wait states ----
        req1_valid = 1; req1_write = 1; req1_addr = 8'h45; req1_wdata = 8'h3C;
        cyc(); check("wr_setup_psel2", PSEL2, 1); check("wr_setup_penable", PENABLE, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("wr_acc_psel2", PSEL2, 1); check("wr_acc_penable", PENABLE, 1);
            check("wr_acc_pwdata", PWDATA, 8'h3C); check("wr_acc_done1", done1, 0);
            if (k == 2) PREADY = 1;
        end
        cyc(); check("wr_done1", done1, 1); check("wr_err", err, 0); check("wr_rdata", rdata, 0);
        PREADY = 0; req1_valid = 0;
        cyc();

        // ---- contention from reset: grants alternate starting with 0 ----
        PRESET = 1;
        req0_valid = 1; req0_write = 0; req0_addr = 8'h03;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h44;
        PREADY = 1;
        cyc(); cyc(); PRESET = 0;
        after_done = 0; prev = 0;
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            cyc();
            if (after_done) begin
                check("rr_setup_next", 32'((PSEL1 | PSEL2) && !PENABLE), 1);
                check("rr_setup_other", PADDR, (prev == 0) ? 8'h44 : 8'h03);
            end
            after_done = done0 | done1;
            if (done0) begin seq.push_back(0); prev = 0; end
            if (done1) begin seq.push_back(1); prev = 1; end
        end
        req0_valid = 0; req1_valid = 0; PREADY = 0;
        check("rr_count", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++) check("rr_order", seq[i], i % 2);
        repeat (25) cyc();

        // ---- timeout: PREADY never comes ----
        req0_valid = 1; req0_write = 0; req0_addr = 8'h10; PRDATA1 = 8'hEE;
        acc = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            cyc();
            if (PENABLE) acc++;
            if (done0 | done1) begin
                got = 1;
                check("to_done0", done0, 1); check("to_err", err, 1);
                check("to_rdata", rdata, 0); check("to_psel1", PSEL1, 0);
                check("to_penable", PENABLE, 0);
            end
        end
        check("to_seen", got, 1);
        check("to_acc_cycles", acc, 16);
        req0_valid = 0;
        cyc();

        // ---- reset in the middle of ACCESS ----
        req0_valid = 1; req0_write = 0; req0_addr = 8'h22; PREADY = 0;
        cyc(); cyc(); check("mr_in_access", PENABLE, 1);
        #2 PRESET = 1;
        #1;
        check("mr_psel1", PSEL1, 0); check("mr_penable", PENABLE, 0);
        check("mr_paddr", PADDR, 0); check("mr_done0", done0, 0);
        check("mr_pwrite", PWRITE, 0); check("mr_pwdata", PWDATA, 0);
        check("mr_rdata", rdata, 0); check("mr_err", err, 0);
        cyc(); check("mr_no_done", done0, 0);
        cyc();
        #2 PRESET = 0;
        cyc(); check("mr_resume_setup", 32'(PSEL1 && !PENABLE), 1);
        PREADY = 1; PRDATA1 = 8'h77;
        cyc(); check("mr_resume_access", PENABLE, 1);
        cyc(); check("mr_resume_done0", done0, 1); check("mr_resume_rdata", rdata, 8'h77);
        req0_valid = 0; PREADY = 0;
        cyc();

        // ---- randomized traffic ----
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if ((c % 500) == 0) stingy = ($urandom_range(0, 2) == 0);
            PREADY  = stingy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) != 0);
            PRDATA1 = 8'($urandom);
            PRDATA2 = 8'($urandom);
            if (!req0_valid || m_done0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_write = 1'($urandom); req0_addr = 8'($urandom); req0_wdata = 8'($urandom);
            end
            if (!req1_valid || m_done1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_write = 1'($urandom); req1_addr = 8'($urandom); req1_wdata = 8'($urandom);
            end
        end
        req0_valid = 0; req1_valid = 0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
